iprf_preimage_streamer: RTL and testbench
=========================================

Name: iprf_preimage_streamer

Overview:
- Downstream stage of the parallel PRP-inverse lane array in the iPRF inverse accelerator.
- On a load pulse, snapshots the array's packed lane results and the valid-lane count. The array is then free to start its next batch.
- Serialises the first num_valid lanes onto a valid/ready stream, one preimage per beat, in lane order.
- Tags any lane value outside [0, domain) as an error and counts such lanes.

Parameters:
WIDTH, 64, bit width of one preimage value
NUM_LANES, 512, number of packed lanes in lanes_in
CNT_W, 16, width of num_valid and the count outputs

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
load  in  1  single-cycle pulse: capture lanes_in, num_valid, domain
lanes_in  in  WIDTH*NUM_LANES  packed lane results; lane i at [i*WIDTH +: WIDTH]
num_valid  in  CNT_W  count of meaningful lanes, lanes 0..num_valid-1
domain  in  WIDTH  iPRF domain n, used for range check
out_valid  out  1  stream beat valid
out_ready  in  1  downstream accepts beat
out_data  out  WIDTH  preimage value
out_index  out  CNT_W  lane index of this beat
out_err  out  1  beat value >= domain
out_last  out  1  final beat of batch
busy  out  1  batch in progress
done  out  1  one-cycle pulse, batch fully emitted
err_cnt  out  CNT_W  out-of-range beats in current/last batch

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; every output 0, including out_data, out_index, err_cnt.
  - Snapshot registers are not required to clear.
  - Reset mid-batch abandons the batch with no done pulse.
- Effective count: limit = min(num_valid, NUM_LANES), latched at load.
- States:
  - IDLE: busy=0.
    - load=1: capture lanes_in, limit, domain; clear err_cnt; set busy=1.
    - limit==0 goes to DONE_ST. Otherwise go to STREAM with beat 0 presented on the next cycle, so out_valid rises exactly one cycle after load.
  - STREAM: output register advances whenever out_valid=0 or out_ready=1 (full throughput, one beat per cycle while out_ready is held high).
    - Beat k presents out_data = lane k, out_index = k, out_err = (lane k >= domain), out_last = (k == limit-1).
    - err_cnt increments in the cycle the erroring beat is accepted (out_valid && out_ready), not when it is presented.
    - Handshake on the out_last beat: out_valid=0 next cycle, then go to DONE_ST.
  - DONE_ST: done=1 for exactly one cycle, busy=0, back to IDLE. err_cnt holds until the next load.
- Stream rules:
  - out_data, out_index, out_err and out_last are stable while out_valid=1 && out_ready=0.
  - out_valid never drops without a handshake.
- Comparison is unsigned, full WIDTH. domain==0 flags every beat.
- load while busy or in DONE_ST is ignored; the snapshot is unchanged.
- load and the final handshake in the same cycle: load ignored.
- Latency: load to done = limit + 1 + stall cycles (limit >= 1); limit==0 gives done 1 cycle after load.
- Lane select is a NUM_LANES:1 mux indexed by a clog2(NUM_LANES)-bit counter; no wrap occurs because the counter stops at limit-1.

Decomposition:
- Shared package iprf_pkg holds WIDTH/NUM_LANES/CNT_W defaults, state encoding localparams (IDLE, STREAM, DONE_ST) and the LANE_IDX_W = clog2(NUM_LANES) constant.
- One natural sub-module, iprf_stream_outreg: a single-entry valid/ready output register carrying data, index, err and last.
- Snapshot, counter and FSM stay in the top.

Test Plan:
- NUM_LANES=8, lanes i*3, num_valid=5, domain=100, out_ready=1 -> out_valid rises 1 cycle after load; beats 0,3,6,9,12 on consecutive cycles with out_index 0..4; out_last on index 4; done 1 cycle after that beat; err_cnt=0.
- Same stimulus, out_ready toggling 1,0,0,1,... -> no beat lost or duplicated; outputs stable during stalls; done latency = 5+1+stall cycles.
- num_valid=0 -> no out_valid; done pulses 1 cycle after load; err_cnt=0.
- num_valid=20 with NUM_LANES=8 -> exactly 8 beats, out_last on index 7.
- domain=10, lanes {2,15,9,10} -> out_err pattern 0,1,0,1; err_cnt=2 after done.
- Second load during STREAM with different lanes_in -> ignored, first batch completes unchanged. Assert rst at beat 2 -> next cycle out_valid=0, busy=0, err_cnt=0, no done. A later load starts cleanly.

Source files
------------

// File: rtl/iprf_pkg.sv
// Shared defaults and state encoding for the iPRF inverse preimage streamer.
package iprf_pkg;

    localparam int unsigned WIDTH_DEF     = 64;
    localparam int unsigned NUM_LANES_DEF = 512;
    localparam int unsigned CNT_W_DEF     = 16;
    localparam int unsigned LANE_IDX_W    = $clog2(NUM_LANES_DEF);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE_ST
    } state_e;

    // Lane counter width; at least one bit so a single-lane build still elaborates.
    function automatic int unsigned lane_idx_w(input int unsigned num_lanes);
        return (num_lanes > 1) ? $clog2(num_lanes) : 1;
    endfunction

endpackage

// File: rtl/iprf_stream_outreg.sv
// Single-entry valid/ready output register carrying one preimage beat.
module iprf_stream_outreg #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CNT_W-1:0] in_index,
    input  logic             in_err,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_index,
    output logic             out_err,
    output logic             out_last
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] index_q;
    logic             err_q;
    logic             last_q;

    // Advance when empty or when the held beat is being taken this cycle.
    assign in_ready = !valid_q || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            index_q <= '0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
        end else if (in_ready) begin
            valid_q <= in_valid;
            if (in_valid) begin
                data_q  <= in_data;
                index_q <= in_index;
                err_q   <= in_err;
                last_q  <= in_last;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_index = index_q;
    assign out_err   = err_q;
    assign out_last  = last_q;

endmodule

// File: rtl/iprf_preimage_streamer.sv
// Snapshots PRP-inverse lane results on load and streams the valid lanes out
// one preimage per beat, flagging and counting values outside [0, domain).
module iprf_preimage_streamer
    import iprf_pkg::*;
#(
    parameter int unsigned WIDTH     = WIDTH_DEF,
    parameter int unsigned NUM_LANES = NUM_LANES_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic [WIDTH*NUM_LANES-1:0] lanes_in,
    input  logic [CNT_W-1:0]           num_valid,
    input  logic [WIDTH-1:0]           domain,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [CNT_W-1:0]           out_index,
    output logic                       out_err,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done,
    output logic [CNT_W-1:0]           err_cnt
);

    localparam int unsigned IDX_W = lane_idx_w(NUM_LANES);

    state_e state_q, state_d;

    logic [WIDTH*NUM_LANES-1:0] lanes_q;
    logic [WIDTH-1:0]           domain_q;
    logic [CNT_W-1:0]           limit_q;
    logic [CNT_W-1:0]           limit_in;
    logic                       capture;

    logic [IDX_W-1:0] sel_q, sel_d;
    logic             issued_last_q, issued_last_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             sel_last;

    logic [WIDTH-1:0] lane_arr [NUM_LANES];
    logic [WIDTH-1:0] lane_sel;

    logic             push_valid;
    logic             push_ready;
    logic [WIDTH-1:0] push_data;
    logic [CNT_W-1:0] push_index;
    logic             push_err;
    logic             push_last;

    assign limit_in = (num_valid > CNT_W'(NUM_LANES)) ? CNT_W'(NUM_LANES) : num_valid;

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_arr[i] = lanes_q[i*WIDTH +: WIDTH];
        end
    end

    assign lane_sel = lane_arr[sel_q];
    assign sel_last = (CNT_W'(sel_q) == limit_q - CNT_W'(1));

    // Snapshot is only written on an accepted load, so it needs no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            lanes_q  <= lanes_in;
            domain_q <= domain;
            limit_q  <= limit_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            sel_q         <= '0;
            issued_last_q <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            issued_last_q <= issued_last_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        issued_last_d = issued_last_q;
        err_cnt_d     = err_cnt_q;
        capture       = 1'b0;
        push_valid    = 1'b0;
        push_data     = lane_sel;
        push_index    = CNT_W'(sel_q);
        push_err      = (lane_sel >= domain_q);
        push_last     = sel_last;

        if (out_valid && out_ready && out_err) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (load) begin
                    capture   = 1'b1;
                    err_cnt_d = '0;
                    if (limit_in == '0) begin
                        state_d = DONE_ST;
                    end else begin
                        // Beat 0 comes straight from the inputs so it is valid next cycle.
                        state_d       = STREAM;
                        push_valid    = 1'b1;
                        push_data     = lanes_in[WIDTH-1:0];
                        push_index    = '0;
                        push_err      = (lanes_in[WIDTH-1:0] >= domain);
                        push_last     = (limit_in == CNT_W'(1));
                        issued_last_d = (limit_in == CNT_W'(1));
                        sel_d         = (limit_in == CNT_W'(1)) ? '0 : IDX_W'(1);
                    end
                end
            end
            STREAM: begin
                if (!issued_last_q) begin
                    push_valid = 1'b1;
                    if (push_ready) begin
                        issued_last_d = sel_last;
                        if (!sel_last) begin
                            sel_d = sel_q + IDX_W'(1);
                        end
                    end
                end
                if (out_valid && out_ready && out_last) begin
                    state_d = DONE_ST;
                end
            end
            DONE_ST: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    iprf_stream_outreg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_outreg (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (push_valid),
        .in_ready  (push_ready),
        .in_data   (push_data),
        .in_index  (push_index),
        .in_err    (push_err),
        .in_last   (push_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_err   (out_err),
        .out_last  (out_last)
    );

    assign busy    = (state_q == STREAM);
    assign done    = (state_q == DONE_ST);
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_iprf_preimage_streamer.sv
// Directed bench for iprf_preimage_streamer with an 8-lane, 64-bit build.
module tb_iprf_preimage_streamer;

    localparam int unsigned WIDTH     = 64;
    localparam int unsigned NUM_LANES = 8;
    localparam int unsigned CNT_W     = 16;

    logic                       clk;
    logic                       rst;
    logic                       load;
    logic [WIDTH*NUM_LANES-1:0] lanes_in;
    logic [CNT_W-1:0]           num_valid;
    logic [WIDTH-1:0]           domain;
    logic                       out_valid;
    logic                       out_ready;
    logic [WIDTH-1:0]           out_data;
    logic [CNT_W-1:0]           out_index;
    logic                       out_err;
    logic                       out_last;
    logic                       busy;
    logic                       done;
    logic [CNT_W-1:0]           err_cnt;

    int checks = 0;
    int errors = 0;

    iprf_preimage_streamer #(
        .WIDTH     (WIDTH),
        .NUM_LANES (NUM_LANES),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .lanes_in  (lanes_in),
        .num_valid (num_valid),
        .domain    (domain),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_err   (out_err),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_lanes(input int mul, input int add);
        for (int i = 0; i < NUM_LANES; i++) begin
            lanes_in[i*WIDTH +: WIDTH] = 64'(i * mul + add);
        end
    endtask

    initial begin
        logic [3:0] pat;
        int         k;
        logic       rdy;

        rst       = 1'b1;
        load      = 1'b0;
        out_ready = 1'b1;
        num_valid = '0;
        domain    = '0;
        lanes_in  = '0;
        @(negedge clk);
        tick();
        tick();

        // Reset state
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", out_data, 64'd0);
        check("rst_index", 64'(out_index), 64'd0);
        check("rst_err", 64'(out_err), 64'd0);
        check("rst_last", 64'(out_last), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_errcnt", 64'(err_cnt), 64'd0);
        rst = 1'b0;
        tick();

        // Full-throughput batch of 5
        set_lanes(3, 0);
        num_valid = 16'd5;
        domain    = 64'd100;
        load      = 1'b1;
        check("t1_pre_valid", 64'(out_valid), 64'd0);
        tick();
        load = 1'b0;
        check("t1_busy", 64'(busy), 64'd1);
        for (int b = 0; b < 5; b++) begin
            check("t1_valid", 64'(out_valid), 64'd1);
            check("t1_data", out_data, 64'(b * 3));
            check("t1_index", 64'(out_index), 64'(b));
            check("t1_last", 64'(out_last), 64'(b == 4));
            check("t1_err", 64'(out_err), 64'd0);
            if (b == 4) load = 1'b1;  // coincides with final handshake, must be ignored
            tick();
        end
        load = 1'b0;
        check("t1_done", 64'(done), 64'd1);
        check("t1_valid_end", 64'(out_valid), 64'd0);
        check("t1_busy_end", 64'(busy), 64'd0);
        check("t1_errcnt", 64'(err_cnt), 64'd0);
        tick();
        check("t1_done_once", 64'(done), 64'd0);
        check("t1_idle_valid", 64'(out_valid), 64'd0);

        // Stalled batch: ready pattern 1,0,0,1 repeating -> handshakes at cycles 1,4,5,8,9
        pat  = 4'b1001;
        load = 1'b1;
        tick();
        load = 1'b0;
        k    = 0;
        for (int c = 1; c <= 9; c++) begin
            rdy       = pat[(c - 1) % 4];
            out_ready = rdy;
            check("t2_valid", 64'(out_valid), 64'd1);
            check("t2_data", out_data, 64'(k * 3));
            check("t2_index", 64'(out_index), 64'(k));
            check("t2_last", 64'(out_last), 64'(k == 4));
            check("t2_done_early", 64'(done), 64'd0);
            tick();
            if (rdy) k++;
        end
        out_ready = 1'b1;
        check("t2_done", 64'(done), 64'd1);
        check("t2_valid_end", 64'(out_valid), 64'd0);
        tick();

        // Empty batch; a load during DONE_ST is ignored
        num_valid = 16'd0;
        load      = 1'b1;
        tick();
        num_valid = 16'd2;
        check("t3_done", 64'(done), 64'd1);
        check("t3_valid", 64'(out_valid), 64'd0);
        check("t3_busy", 64'(busy), 64'd0);
        check("t3_errcnt", 64'(err_cnt), 64'd0);
        tick();
        load = 1'b0;
        check("t3_done_once", 64'(done), 64'd0);
        check("t3_ignored_valid", 64'(out_valid), 64'd0);
        check("t3_ignored_busy", 64'(busy), 64'd0);
        tick();

        // num_valid beyond NUM_LANES clamps to 8 beats
        set_lanes(1, 40);
        num_valid = 16'd20;
        load      = 1'b1;
        tick();
        load = 1'b0;
        for (int b = 0; b < 8; b++) begin
            check("t4_valid", 64'(out_valid), 64'd1);
            check("t4_index", 64'(out_index), 64'(b));
            check("t4_data", out_data, 64'(b + 40));
            check("t4_last", 64'(out_last), 64'(b == 7));
            tick();
        end
        check("t4_done", 64'(done), 64'd1);
        check("t4_valid_end", 64'(out_valid), 64'd0);
        tick();

        // Range check: lanes {2,15,9,10}, domain 10
        lanes_in               = '0;
        lanes_in[0*WIDTH +: WIDTH] = 64'd2;
        lanes_in[1*WIDTH +: WIDTH] = 64'd15;
        lanes_in[2*WIDTH +: WIDTH] = 64'd9;
        lanes_in[3*WIDTH +: WIDTH] = 64'd10;
        num_valid = 16'd4;
        domain    = 64'd10;
        load      = 1'b1;
        tick();
        load = 1'b0;
        check("t5_err0", 64'(out_err), 64'd0);
        check("t5_cnt0", 64'(err_cnt), 64'd0);
        tick();
        check("t5_err1", 64'(out_err), 64'd1);
        check("t5_cnt1", 64'(err_cnt), 64'd0);
        tick();
        check("t5_err2", 64'(out_err), 64'd0);
        check("t5_cnt2", 64'(err_cnt), 64'd1);
        tick();
        check("t5_err3", 64'(out_err), 64'd1);
        check("t5_last3", 64'(out_last), 64'd1);
        tick();
        check("t5_done", 64'(done), 64'd1);
        check("t5_errcnt", 64'(err_cnt), 64'd2);
        tick();
        check("t5_errcnt_hold", 64'(err_cnt), 64'd2);

        // Second load mid-stream is ignored
        set_lanes(3, 0);
        num_valid = 16'd5;
        domain    = 64'd100;
        load      = 1'b1;
        tick();
        check("t6_data0", out_data, 64'd0);
        set_lanes(7, 1);
        num_valid = 16'd3;
        tick();
        load = 1'b0;
        for (int b = 1; b < 5; b++) begin
            check("t6_data", out_data, 64'(b * 3));
            check("t6_index", 64'(out_index), 64'(b));
            check("t6_last", 64'(out_last), 64'(b == 4));
            tick();
        end
        check("t6_done", 64'(done), 64'd1);
        tick();

        // Reset at beat 2 abandons the batch
        set_lanes(3, 0);
        num_valid = 16'd5;
        domain    = 64'd2;
        load      = 1'b1;
        tick();
        load = 1'b0;
        tick();
        check("t7_beat1_err", 64'(out_err), 64'd1);
        tick();
        check("t7_beat2_data", out_data, 64'd6);
        check("t7_cnt_before", 64'(err_cnt), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t7_valid", 64'(out_valid), 64'd0);
        check("t7_busy", 64'(busy), 64'd0);
        check("t7_errcnt", 64'(err_cnt), 64'd0);
        check("t7_done", 64'(done), 64'd0);
        tick();
        check("t7_no_done", 64'(done), 64'd0);

        // Clean restart after reset
        set_lanes(5, 0);
        num_valid = 16'd3;
        domain    = 64'd100;
        load      = 1'b1;
        tick();
        load = 1'b0;
        for (int b = 0; b < 3; b++) begin
            check("t8_valid", 64'(out_valid), 64'd1);
            check("t8_data", out_data, 64'(b * 5));
            check("t8_index", 64'(out_index), 64'(b));
            tick();
        end
        check("t8_done", 64'(done), 64'd1);
        check("t8_errcnt", 64'(err_cnt), 64'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
